regfile_wr_ctrl: RTL and testbench

Write-port controller for the 32x32 register file in the MIPS pipeline. The register file has one write port, and this block shares it between the WB stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO. After reset the block sequences a hardware clear of r1..r31, because the register file has no reset of its own. It also flags read-after-write hazards against queued MDU results so decode can stall.

---
 rtl/regfile_wr_ctrl.sv | 136 +++++++++++++
 tb/tb_regfile_wr_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port arbiter: shares the single write port between the WB stage
// and a small MDU result FIFO, and zeroes r1..r31 after reset since the regfile has no reset.
module regfile_wr_ctrl #(
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_write,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [4:0]        mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    input  logic [4:0]        rdAddrA,
    input  logic [4:0]        rdAddrB,
    output logic              hazA,
    output logic              hazB,
    output logic              rf_write,
    output logic [4:0]        rf_wrAddr,
    output logic [DATA_W-1:0] rf_wrData,
    output logic              stall,
    output logic              busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic {CLEAR, RUN} ctrlState_t;

    ctrlState_t           state;
    logic [4:0]           clrCnt;
    logic [STV_W-1:0]     starveCnt;
    logic [PTR_W-1:0]     rdPtr;
    logic [PTR_W-1:0]     wrPtr;
    logic [FIFO_DEPTH-1:0] slotValid;
    logic [4:0]           fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0]    fifoData [FIFO_DEPTH];

    logic running;
    logic empty;
    logic full;
    logic wbWr;
    logic starve;
    logic headWrite;
    logic push;

    // Starvation overrides WB; otherwise WB wins and the FIFO head only drains in idle WB cycles.
    always_comb begin
        running   = reset && (state == RUN);
        empty     = (slotValid == '0);
        full      = &slotValid;
        wbWr      = wb_write && (wb_addr != 5'd0);
        starve    = running && !empty && (starveCnt == STV_W'(STARVE_LIMIT));
        headWrite = running && !empty && (starve || !wbWr);
        mdu_ready = running && (!full || headWrite);
        push      = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
    end

    always_comb begin
        rf_write  = 1'b0;
        rf_wrAddr = 5'd0;
        rf_wrData = '0;
        stall     = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            stall = 1'b1;
            busy  = CLEAR_ON_RESET;
        end else if (state == CLEAR) begin
            rf_write  = 1'b1;
            rf_wrAddr = clrCnt;
            stall     = 1'b1;
            busy      = 1'b1;
        end else if (headWrite) begin
            rf_write  = 1'b1;
            rf_wrAddr = fifoAddr[rdPtr];
            rf_wrData = fifoData[rdPtr];
            stall     = starve;
        end else if (wbWr) begin
            rf_write  = 1'b1;
            rf_wrAddr = wb_addr;
            rf_wrData = wb_data;
        end
    end

    // Entries never hold r0, so the explicit r0 guard only matters for the read side.
    always_comb begin
        hazA = 1'b0;
        hazB = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (reset && slotValid[i] && (rdAddrA != 5'd0) && (fifoAddr[i] == rdAddrA)) hazA = 1'b1;
            if (reset && slotValid[i] && (rdAddrB != 5'd0) && (fifoAddr[i] == rdAddrB)) hazB = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clrCnt    <= 5'd1;
            starveCnt <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            slotValid <= '0;
        end else begin
            if (state == CLEAR) begin
                clrCnt <= clrCnt + 5'd1;
                if (clrCnt == 5'd31) state <= RUN;
            end
            if (headWrite) begin
                slotValid[rdPtr] <= 1'b0;
                rdPtr            <= rdPtr + PTR_W'(1);
            end
            // A push into the slot being popped must win, hence it comes last.
            if (push) begin
                slotValid[wrPtr] <= 1'b1;
                wrPtr            <= wrPtr + PTR_W'(1);
            end
            if (empty || headWrite) begin
                starveCnt <= '0;
            end else if (running && (starveCnt != STV_W'(STARVE_LIMIT))) begin
                starveCnt <= starveCnt + STV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtr] <= mdu_addr;
            fifoData[wrPtr] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Scoreboard bench for regfile_wr_ctrl: a queue-based model predicts every register-file
// write and the control flags each cycle; a negedge monitor compares against the DUT.
module tb_regfile_wr_ctrl;

    localparam int DATA_W         = 32;
    localparam int FIFO_DEPTH     = 2;
    localparam int STARVE_LIMIT   = 4;
    localparam bit CLEAR_ON_RESET = 1'b1;

    logic              clk = 1'b0;
    logic              reset;
    logic              wb_write;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mdu_valid;
    logic [4:0]        mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;
    logic [4:0]        rdAddrA;
    logic [4:0]        rdAddrB;
    logic              hazA;
    logic              hazB;
    logic              rf_write;
    logic [4:0]        rf_wrAddr;
    logic [DATA_W-1:0] rf_wrData;
    logic              stall;
    logic              busy;

    regfile_wr_ctrl #(
        .DATA_W(DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wb_write(wb_write),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .mdu_valid(mdu_valid),
        .mdu_addr(mdu_addr),
        .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rdAddrA(rdAddrA),
        .rdAddrB(rdAddrB),
        .hazA(hazA),
        .hazB(hazB),
        .rf_write(rf_write),
        .rf_wrAddr(rf_wrAddr),
        .rf_wrData(rf_wrData),
        .stall(stall),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wrT;

    typedef struct packed {
        logic inReset;
        logic rfWrite;
        logic stall;
        logic busy;
        logic ready;
        logic hazA;
        logic hazB;
    } ctlT;

    wrT  expWrQ[$];
    ctlT ctlQ[$];
    wrT  modelFifo[$];
    wrT  mduSendQ[$];

    int   waitCnt;
    int   clearIdx;
    logic lastStarve;
    logic mduAccepted;
    int   checks   = 0;
    int   failures = 0;

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input ctlT c);
        wrT e;
        checkBit("rf_write", rf_write, c.rfWrite);
        checkBit("stall", stall, c.stall);
        checkBit("busy", busy, c.busy);
        checkBit("mdu_ready", mdu_ready, c.ready);
        checkBit("hazA", hazA, c.hazA);
        checkBit("hazB", hazB, c.hazB);
        if (c.inReset) begin
            checkVal("rf_wrAddr_in_reset", 32'(rf_wrAddr), 32'd0);
            checkVal("rf_wrData_in_reset", rf_wrData, 32'd0);
        end
        if (rf_write === 1'b1) begin
            if (expWrQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h expected no write at %0t",
                         rf_wrAddr, rf_wrData, $time);
            end else begin
                e = expWrQ.pop_front();
                checkVal("write_addr", 32'(rf_wrAddr), 32'(e.addr));
                checkVal("write_data", rf_wrData, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ctlQ.size() > 0) checkOutput(ctlQ.pop_front());
    end

    // Reference behaviour for the cycle whose inputs were just applied; edge effects applied at the end.
    task automatic modelCycle();
        ctlT c;
        wrT  w;
        bit  starve;
        bit  wbw;
        bit  headW;
        bit  wasEmpty;
        c = '0;
        if (!reset) begin
            c.inReset = 1'b1;
            c.stall   = 1'b1;
            c.busy    = CLEAR_ON_RESET;
            modelFifo.delete();
            waitCnt    = 0;
            clearIdx   = CLEAR_ON_RESET ? 1 : 32;
            lastStarve = 1'b0;
        end else if (clearIdx <= 31) begin
            c.rfWrite = 1'b1;
            c.stall   = 1'b1;
            c.busy    = 1'b1;
            w.addr    = clearIdx[4:0];
            w.data    = '0;
            expWrQ.push_back(w);
            clearIdx++;
            lastStarve = 1'b0;
        end else begin
            wasEmpty = (modelFifo.size() == 0);
            starve   = !wasEmpty && (waitCnt == STARVE_LIMIT);
            wbw      = wb_write && (wb_addr != 5'd0);
            headW    = !wasEmpty && (starve || !wbw);
            foreach (modelFifo[i]) begin
                if (rdAddrA != 5'd0 && modelFifo[i].addr == rdAddrA) c.hazA = 1'b1;
                if (rdAddrB != 5'd0 && modelFifo[i].addr == rdAddrB) c.hazB = 1'b1;
            end
            c.ready = (modelFifo.size() < FIFO_DEPTH) || headW;
            c.stall = starve;
            if (headW) begin
                c.rfWrite = 1'b1;
                expWrQ.push_back(modelFifo.pop_front());
            end else if (wbw) begin
                c.rfWrite = 1'b1;
                w.addr    = wb_addr;
                w.data    = wb_data;
                expWrQ.push_back(w);
            end
            if (wasEmpty || headW) waitCnt = 0;
            else if (waitCnt < STARVE_LIMIT) waitCnt++;
            if (mdu_valid && c.ready) begin
                mduAccepted = 1'b1;
                if (mdu_addr != 5'd0) begin
                    w.addr = mdu_addr;
                    w.data = mdu_data;
                    modelFifo.push_back(w);
                end
            end
            lastStarve = starve;
        end
        ctlQ.push_back(c);
    endtask

    // WB inputs are frozen after a starvation cycle; MDU results are held until accepted.
    task automatic applyStimulus(input logic rstVal, input logic wbW, input logic [4:0] wbA,
                                 input logic [31:0] wbD, input logic [4:0] rdA, input logic [4:0] rdB);
        wrT m;
        @(posedge clk);
        #1;
        reset = rstVal;
        if (mduAccepted || !rstVal) mdu_valid = 1'b0;
        mduAccepted = 1'b0;
        if (rstVal && !mdu_valid && mduSendQ.size() > 0) begin
            m         = mduSendQ.pop_front();
            mdu_valid = 1'b1;
            mdu_addr  = m.addr;
            mdu_data  = m.data;
        end
        if (!lastStarve) begin
            wb_write = wbW;
            wb_addr  = wbA;
            wb_data  = wbD;
        end
        rdAddrA = rdA;
        rdAddrB = rdB;
        modelCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        logic [4:0] rdA;
        logic [4:0] rdB;
        logic       rst;
        wrT         m;
        reset       = 1'b0;
        wb_write    = 1'b0;
        wb_addr     = 5'd0;
        wb_data     = '0;
        mdu_valid   = 1'b0;
        mdu_addr    = 5'd0;
        mdu_data    = '0;
        rdAddrA     = 5'd0;
        rdAddrB     = 5'd0;
        waitCnt     = 0;
        clearIdx    = 1;
        lastStarve  = 1'b0;
        mduAccepted = 1'b0;

        $display("[TB] reset and clear sequence");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(34);

        $display("[TB] WB pass-through and r0 suppression");
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h00000055, 5'd0, 5'd0);

        $display("[TB] MDU r9 starved behind WB traffic");
        m = {5'd9, 32'h00001234};
        mduSendQ.push_back(m);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 5'd3, $urandom, 5'd9, 5'd3);
        idle(3);

        $display("[TB] FIFO full with r7, r8 then a third result");
        m = {5'd7, $urandom};
        mduSendQ.push_back(m);
        m = {5'd8, $urandom};
        mduSendQ.push_back(m);
        m = {5'd10, $urandom};
        mduSendQ.push_back(m);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 5'd3, $urandom, 5'd7, 5'd8);
        idle(4);

        $display("[TB] MDU result to r0");
        m = {5'd0, 32'hCAFEF00D};
        mduSendQ.push_back(m);
        idle(4);

        $display("[TB] reset in the middle of the clear");
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 40 && clearIdx != 17; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(35);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0 && mduSendQ.size() < 2) begin
                m.addr = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                m.data = $urandom;
                mduSendQ.push_back(m);
            end
            rst = ($urandom_range(0, 999) != 0);
            rdA = (modelFifo.size() > 0 && $urandom_range(0, 1) == 1) ? modelFifo[0].addr : 5'($urandom_range(0, 31));
            rdB = (modelFifo.size() > 1 && $urandom_range(0, 1) == 1) ? modelFifo[1].addr : 5'($urandom_range(0, 31));
            applyStimulus(rst, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, rdA, rdB);
        end
        idle(40);

        @(negedge clk);
        #1;
        checkVal("write_queue_drained", 32'(expWrQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
